// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
//   seq_state_t        : sequencer FSM states
//   DEFAULT_CLK_PER_MS : board clock (54 MHz) expressed in cycles per millisecond
//   cycles_from_ms()   : converts a millisecond interval into clock cycles
//   width_of()         : bits needed to hold n distinct values (never less than 1)
package reset_seq_pkg;

   localparam int unsigned DEFAULT_CLK_PER_MS = 54000;

   typedef enum logic [2:0] {
      StIdle,
      StHold,
      StWait,
      StDone,
      StFault
   } seq_state_t;

   function automatic int unsigned cycles_from_ms(input int unsigned ms,
                                                  input int unsigned clk_per_ms);
      return ms * clk_per_ms;
   endfunction

   // Keeps derived vector widths legal when a parameter degenerates to 1 value.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Interval timer shared by the hold and ready-timeout phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (takes priority over en)
//   en         : advance the count by one this cycle
//   term       : terminal value for the interval currently being timed
//   at_term    : count equals term; the count returns to zero on the next enabled edge
module seq_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] term,
   output logic             at_term
);

   logic [WIDTH-1:0] cnt_d, cnt_q;

   assign at_term = (cnt_q == term);

   // Clearing at the terminal value means the count can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_term ? '0 : cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged power-up reset sequencer. Releases each downstream subsystem in turn: holds its
// reset for a fixed time, releases it, then waits (with timeout and bounded retries) for
// its ready before moving on. A ready dropping after completion shuts everything down.
//   clk, rst_n   : board clock, asynchronous active-low reset
//   start        : one-cycle restart request, honoured only in DONE or FAULT
//   stage_ready  : per-stage ready, synchronous to clk
//   stage_rst_n  : per-stage active-low reset (registered)
//   busy         : hold or wait phase in progress
//   all_ready    : every stage released and reporting ready
//   error        : sequence halted in FAULT
//   err_stage    : failing stage index, meaningful while error is high
//   retry_cnt    : retries consumed on the current stage
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned CLK_PER_MS  = DEFAULT_CLK_PER_MS,
   parameter int unsigned N_STAGES    = 4,
   parameter int unsigned HOLD_MS     = 10,
   parameter int unsigned TIMEOUT_MS  = 100,
   parameter int unsigned MAX_RETRIES = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [N_STAGES-1:0]                  stage_ready,
   output logic [N_STAGES-1:0]                  stage_rst_n,
   output logic                                 busy,
   output logic                                 all_ready,
   output logic                                 error,
   output logic [width_of(N_STAGES)-1:0]        err_stage,
   output logic [width_of(MAX_RETRIES+1)-1:0]   retry_cnt
);

   localparam int unsigned HOLD_CYC = cycles_from_ms(HOLD_MS, CLK_PER_MS);
   localparam int unsigned TO_CYC   = cycles_from_ms(TIMEOUT_MS, CLK_PER_MS);
   localparam int unsigned CNT_MAX  = (HOLD_CYC > TO_CYC) ? HOLD_CYC : TO_CYC;
   localparam int unsigned CW       = width_of(CNT_MAX);
   localparam int unsigned SW       = width_of(N_STAGES);
   localparam int unsigned RW       = width_of(MAX_RETRIES + 1);

   localparam logic [CW-1:0] HOLD_TERM   = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] TO_TERM     = CW'(TO_CYC - 1);
   localparam logic [SW-1:0] LAST_IDX    = SW'(N_STAGES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

   if (HOLD_CYC == 0) begin : g_chk_hold
      $error("reset_sequencer: HOLD_CYC must be at least 1");
   end
   if (TO_CYC == 0) begin : g_chk_timeout
      $error("reset_sequencer: TO_CYC must be at least 1");
   end
   if (N_STAGES == 0) begin : g_chk_stages
      $error("reset_sequencer: N_STAGES must be at least 1");
   end

   seq_state_t          state_d, state_q;
   logic [SW-1:0]       idx_d, idx_q;
   logic [RW-1:0]       retry_d, retry_q;
   logic [N_STAGES-1:0] rst_d, rst_q;
   logic                busy_d, busy_q;
   logic                all_ready_d, all_ready_q;
   logic                error_d, error_q;
   logic [SW-1:0]       err_stage_d, err_stage_q;
   logic [SW-1:0]       drop_idx;
   logic                tmr_clr, tmr_en, tmr_at_term;
   logic [CW-1:0]       tmr_term;

   // Every state change (including a retry back into HOLD) starts a fresh interval.
   assign tmr_clr  = (state_d != state_q);
   assign tmr_en   = (state_q == StHold) || (state_q == StWait);
   assign tmr_term = (state_q == StHold) ? HOLD_TERM : TO_TERM;

   seq_timer #(
      .WIDTH (CW)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .term    (tmr_term),
      .at_term (tmr_at_term)
   );

   // Lowest-numbered stage whose ready has dropped.
   always_comb begin
      drop_idx = '0;
      for (int i = N_STAGES - 1; i >= 0; i--) begin
         if (!stage_ready[i]) begin
            drop_idx = SW'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      retry_d     = retry_q;
      rst_d       = rst_q;
      busy_d      = busy_q;
      all_ready_d = all_ready_q;
      error_d     = error_q;
      err_stage_d = err_stage_q;

      unique case (state_q)
         StIdle: begin
            state_d = StHold;
            idx_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
         end

         StHold: begin
            if (tmr_at_term) begin
               state_d      = StWait;
               rst_d[idx_q] = 1'b1;
            end
         end

         StWait: begin
            // Ready is checked first so it wins over a coincident timeout.
            if (stage_ready[idx_q]) begin
               retry_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d     = StDone;
                  busy_d      = 1'b0;
                  all_ready_d = 1'b1;
               end else begin
                  state_d = StHold;
                  idx_d   = idx_q + SW'(1);
               end
            end else if (tmr_at_term) begin
               if (retry_q < RETRY_LIMIT) begin
                  state_d      = StHold;
                  rst_d[idx_q] = 1'b0;
                  retry_d      = retry_q + RW'(1);
               end else begin
                  state_d     = StFault;
                  rst_d       = '0;
                  busy_d      = 1'b0;
                  error_d     = 1'b1;
                  err_stage_d = idx_q;
               end
            end
         end

         StDone: begin
            if (start) begin
               state_d     = StHold;
               idx_d       = '0;
               retry_d     = '0;
               rst_d       = '0;
               busy_d      = 1'b1;
               all_ready_d = 1'b0;
               error_d     = 1'b0;
            end else if (!(&stage_ready)) begin
               state_d     = StFault;
               rst_d       = '0;
               all_ready_d = 1'b0;
               error_d     = 1'b1;
               err_stage_d = drop_idx;
            end
         end

         StFault: begin
            if (start) begin
               state_d     = StHold;
               idx_d       = '0;
               retry_d     = '0;
               rst_d       = '0;
               busy_d      = 1'b1;
               all_ready_d = 1'b0;
               error_d     = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
            rst_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         retry_q     <= '0;
         rst_q       <= '0;
         busy_q      <= 1'b0;
         all_ready_q <= 1'b0;
         error_q     <= 1'b0;
         err_stage_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         rst_q       <= rst_d;
         busy_q      <= busy_d;
         all_ready_q <= all_ready_d;
         error_q     <= error_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign stage_rst_n = rst_q;
   assign busy        = busy_q;
   assign all_ready   = all_ready_q;
   assign error       = error_q;
   assign err_stage   = err_stage_q;
   assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD_CYC=8, TO_CYC=20, three stages, one retry.
// A small responder raises each stage_ready a programmable number of cycles after that
// stage's reset is released (per attempt, -1 = never); expected cycle counts are fixed
// constants worked out by hand from the sequencing rules.
module tb_reset_sequencer;

   localparam int NS     = 3;
   localparam int W_FALL = 8;
   localparam int W_ALL  = 16;
   localparam int W_ERR  = 17;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [NS-1:0] stage_ready;
   logic [NS-1:0] stage_rst_n;
   logic          busy;
   logic          all_ready;
   logic          error;
   logic [1:0]    err_stage;
   logic [0:0]    retry_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   int            dly_first [NS];
   int            dly_retry [NS];
   int            attempt   [NS];
   int            rel_cnt   [NS];
   logic [NS-1:0] ready_q;
   logic [NS-1:0] prev_rst;
   logic [NS-1:0] drop;

   reset_sequencer #(
      .CLK_PER_MS  (4),
      .N_STAGES    (NS),
      .HOLD_MS     (2),
      .TIMEOUT_MS  (5),
      .MAX_RETRIES (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stage_ready (stage_ready),
      .stage_rst_n (stage_rst_n),
      .busy        (busy),
      .all_ready   (all_ready),
      .error       (error),
      .err_stage   (err_stage),
      .retry_cnt   (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic update_ready();
      int d;
      for (int i = 0; i < NS; i++) begin
         if (!stage_rst_n[i]) begin
            rel_cnt[i] = 0;
            ready_q[i] = 1'b0;
         end else begin
            if (!prev_rst[i]) begin
               attempt[i]++;
               rel_cnt[i] = 0;
            end else begin
               rel_cnt[i]++;
            end
            d = (attempt[i] <= 1) ? dly_first[i] : dly_retry[i];
            if (d >= 0 && rel_cnt[i] >= d) ready_q[i] = 1'b1;
         end
         prev_rst[i] = stage_rst_n[i];
      end
      stage_ready = ready_q & ~drop;
   endtask

   task automatic arm(input int f0, input int f1, input int f2,
                      input int r0, input int r1, input int r2);
      dly_first[0] = f0; dly_first[1] = f1; dly_first[2] = f2;
      dly_retry[0] = r0; dly_retry[1] = r1; dly_retry[2] = r2;
      for (int i = 0; i < NS; i++) begin
         attempt[i] = 0;
         rel_cnt[i] = 0;
      end
      ready_q     = '0;
      prev_rst    = '0;
      stage_ready = ready_q & ~drop;
   endtask

   // One clock: sample 1 time unit after the rising edge, then update the responder.
   task automatic step();
      @(posedge clk);
      #1;
      update_ready();
   endtask

   function automatic logic cond(input int sel);
      if (sel < W_FALL) return stage_rst_n[sel];
      if (sel < W_ALL)  return !stage_rst_n[sel - W_FALL];
      if (sel == W_ALL) return all_ready;
      return error;
   endfunction

   // Counts edges until the selected condition holds; returns budget if it never does.
   task automatic wait_for(input int sel, input int budget, output int n);
      n = 0;
      while (!cond(sel) && n < budget) begin
         step();
         n++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int n;
      rst_n       = 1'b0;
      start       = 1'b0;
      drop        = '0;
      stage_ready = '0;
      arm(3, 3, 3, 3, 3, 3);

      // Reset values
      repeat (3) step();
      check_eq("rst_stage_rst_n", int'(stage_rst_n), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_all_ready", int'(all_ready), 0);
      check_eq("rst_error", int'(error), 0);
      check_eq("rst_err_stage", int'(err_stage), 0);
      check_eq("rst_retry_cnt", int'(retry_cnt), 0);

      // Nominal: 1 idle edge + 8 hold edges, then 3 ready + 1 + 8 hold per later stage
      rst_n = 1'b1;
      wait_for(0, 40, n);     check_eq("nom_rise0", n, 9);
      wait_for(1, 40, n);     check_eq("nom_rise1", n, 12);
      check_eq("nom_stage0_kept", int'(stage_rst_n[0]), 1);
      wait_for(2, 40, n);     check_eq("nom_rise2", n, 12);
      wait_for(W_ALL, 40, n); check_eq("nom_all_ready_lat", n, 4);
      check_eq("nom_busy", int'(busy), 0);
      check_eq("nom_error", int'(error), 0);
      check_eq("nom_stage_rst_n", int'(stage_rst_n), 7);

      // Single retry on stage 1; arm() drops every ready while start is high: start wins
      arm(3, -1, 3, 3, 2, 3);
      pulse_start();
      check_eq("rty_start_wins_error", int'(error), 0);
      check_eq("rty_start_busy", int'(busy), 1);
      check_eq("rty_start_all_ready", int'(all_ready), 0);
      check_eq("rty_start_stage_rst_n", int'(stage_rst_n), 0);
      wait_for(0, 40, n);          check_eq("rty_rise0", n, 8);
      wait_for(1, 40, n);          check_eq("rty_rise1", n, 12);
      wait_for(W_FALL + 1, 40, n); check_eq("rty_fall1", n, 20);
      check_eq("rty_retry_cnt", int'(retry_cnt), 1);
      check_eq("rty_stage0_kept", int'(stage_rst_n[0]), 1);
      wait_for(1, 40, n);          check_eq("rty_rehold1", n, 8);
      wait_for(2, 40, n);          check_eq("rty_rise2", n, 11);
      check_eq("rty_retry_cleared", int'(retry_cnt), 0);
      wait_for(W_ALL, 40, n);      check_eq("rty_all_ready_lat", n, 4);

      // Fault: stage 2 never ready
      arm(3, 3, -1, 3, 3, -1);
      pulse_start();
      wait_for(0, 40, n);          check_eq("flt_rise0", n, 8);
      wait_for(1, 40, n);          check_eq("flt_rise1", n, 12);
      wait_for(2, 40, n);          check_eq("flt_rise2", n, 12);
      wait_for(W_FALL + 2, 40, n); check_eq("flt_timeout1", n, 20);
      check_eq("flt_retry_cnt", int'(retry_cnt), 1);
      wait_for(2, 40, n);          check_eq("flt_rehold2", n, 8);
      wait_for(W_ERR, 40, n);      check_eq("flt_timeout2", n, 20);
      check_eq("flt_err_stage", int'(err_stage), 2);
      check_eq("flt_stage_rst_n", int'(stage_rst_n), 0);
      check_eq("flt_busy", int'(busy), 0);
      check_eq("flt_all_ready", int'(all_ready), 0);

      // Restart from FAULT; stage 0 ready lands exactly on the timeout cycle
      arm(19, 3, 3, 19, 3, 3);
      pulse_start();
      check_eq("rst_from_fault_error", int'(error), 0);
      check_eq("rst_from_fault_busy", int'(busy), 1);
      check_eq("rst_from_fault_stage_rst_n", int'(stage_rst_n), 0);
      check_eq("rst_from_fault_retry", int'(retry_cnt), 0);
      wait_for(0, 40, n);     check_eq("bnd_rise0", n, 8);
      wait_for(1, 60, n);     check_eq("bnd_rise1", n, 28);
      check_eq("bnd_retry_cnt", int'(retry_cnt), 0);
      check_eq("bnd_stage0_kept", int'(stage_rst_n[0]), 1);
      wait_for(2, 40, n);     check_eq("bnd_rise2", n, 12);
      wait_for(W_ALL, 40, n); check_eq("bnd_all_ready_lat", n, 4);

      // Dropout of stage 1 for one cycle while DONE
      drop = 3'b010;
      update_ready();
      step();
      drop = '0;
      check_eq("drop_error", int'(error), 1);
      check_eq("drop_err_stage", int'(err_stage), 1);
      check_eq("drop_all_ready", int'(all_ready), 0);
      check_eq("drop_stage_rst_n", int'(stage_rst_n), 0);
      check_eq("drop_busy", int'(busy), 0);

      // Mid-sequence reset during stage 1's second wait
      arm(3, -1, 3, 3, -1, 3);
      pulse_start();
      wait_for(0, 40, n);          check_eq("mid_rise0", n, 8);
      wait_for(1, 40, n);          check_eq("mid_rise1", n, 12);
      wait_for(W_FALL + 1, 40, n); check_eq("mid_fall1", n, 20);
      wait_for(1, 40, n);          check_eq("mid_rehold1", n, 8);
      repeat (3) step();
      check_eq("mid_pre_retry", int'(retry_cnt), 1);
      check_eq("mid_pre_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_async_stage_rst_n", int'(stage_rst_n), 0);
      check_eq("mid_async_busy", int'(busy), 0);
      check_eq("mid_async_retry", int'(retry_cnt), 0);
      check_eq("mid_async_error", int'(error), 0);
      check_eq("mid_async_err_stage", int'(err_stage), 0);
      check_eq("mid_async_all_ready", int'(all_ready), 0);
      #2 rst_n = 1'b1;
      arm(3, 3, 3, 3, 3, 3);
      wait_for(0, 40, n);     check_eq("mid_rerun_rise0", n, 9);
      wait_for(1, 40, n);     check_eq("mid_rerun_rise1", n, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
